// File: rtl/zxuno_register_initiator.sv
// rtl/zxuno_register_initiator.sv - Z80 I/O bridge to the ZX-Uno register bank (address/data port pair)
// Optional build macro: ZXUNO_ADDR_AUTOINC_EN (register address auto-increments after each data access)
module zxuno_register_initiator #(
  parameter logic [15:0] ADDRPORT = 16'hFC3B,
  parameter logic [15:0] DATAPORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wdata,
  input  logic [7:0]  reg_din,
  input  logic        reg_oe_n
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_WR,
    DATA_WR,
    DATA_RD,
    WAIT_RELEASE
  } state_t;

  state_t state;

  logic dec_addr;
  logic dec_data;
  logic bus_sel;
  logic strb;
  logic rd_ok;

  assign dec_addr = (a == ADDRPORT);
  assign dec_data = (a == DATAPORT);
  assign bus_sel  = !iorq_n && m1_n && (dec_addr || dec_data);
  assign strb     = bus_sel && (rd_n ^ wr_n);
  assign rd_ok    = bus_sel && !rd_n && wr_n;

  // Port and direction travel with the strobe so the FSM sees a coherent snapshot.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic       s_strb;
  logic       s_data;
  logic       s_wr;

  assign s_strb = sync2[2];
  assign s_data = sync2[1];
  assign s_wr   = sync2[0];

  // armed stays low until the synchronizer holds real bus samples after reset,
  // so an access still in flight at reset release cannot look released.
  logic [1:0] armed;

`ifdef ZXUNO_ADDR_AUTOINC_EN
  logic from_wr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 3'b000;
      sync2       <= 3'b000;
      armed       <= 2'b00;
      state       <= WAIT_RELEASE;
      zxuno_addr  <= 8'h00;
      zxuno_wdata <= 8'h00;
      zxuno_regrd <= 1'b0;
      zxuno_regwr <= 1'b0;
`ifdef ZXUNO_ADDR_AUTOINC_EN
      from_wr     <= 1'b0;
`endif
    end else begin
      sync1 <= {strb, dec_data, !wr_n};
      sync2 <= sync1;
      armed <= {armed[0], 1'b1};
      case (state)
        IDLE: begin
          if (s_strb) begin
            if (s_wr && !s_data) begin
              zxuno_addr <= cpu_din;
              state      <= ADDR_WR;
            end else if (s_wr && s_data) begin
              zxuno_wdata <= cpu_din;
              zxuno_regwr <= 1'b1;
              state       <= DATA_WR;
            end else if (s_data) begin
              zxuno_regrd <= 1'b1;
              state       <= DATA_RD;
            end
          end
        end
        ADDR_WR: begin
          state <= WAIT_RELEASE;
        end
        DATA_WR: begin
          zxuno_regwr <= 1'b0;
`ifdef ZXUNO_ADDR_AUTOINC_EN
          from_wr     <= 1'b1;
`endif
          state       <= WAIT_RELEASE;
        end
        DATA_RD: begin
          if (!s_strb) begin
            zxuno_regrd <= 1'b0;
`ifdef ZXUNO_ADDR_AUTOINC_EN
            zxuno_addr  <= zxuno_addr + 8'd1;
`endif
            state       <= IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (armed[1] && !s_strb) begin
`ifdef ZXUNO_ADDR_AUTOINC_EN
            if (from_wr) zxuno_addr <= zxuno_addr + 8'd1;
            from_wr <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= WAIT_RELEASE;
      endcase
    end
  end

  // Read data must be on the bus within the same Z80 cycle, hence no synchronizer here.
  always_comb begin
    cpu_oe_n = 1'b1;
    cpu_dout = 8'h00;
    if (rd_ok && dec_addr) begin
      cpu_oe_n = 1'b0;
      cpu_dout = zxuno_addr;
    end else if (rd_ok && dec_data && !reg_oe_n) begin
      cpu_oe_n = 1'b0;
      cpu_dout = reg_din;
    end
  end

endmodule

// File: tb/tb_zxuno_register_initiator.sv
// tb/tb_zxuno_register_initiator.sv - directed self-checking bench for zxuno_register_initiator
module tb_zxuno_register_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n, m1_n;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic [7:0]  zxuno_wdata;
  logic [7:0]  reg_din;
  logic        reg_oe_n;

`ifdef ZXUNO_ADDR_AUTOINC_EN
  localparam logic [7:0] AINC = 8'd1;
`else
  localparam logic [7:0] AINC = 8'd0;
`endif

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;
  logic [7:0] pulse_wdata = 8'h00;
  logic [7:0] pulse_addr  = 8'h00;
  int p0;
  logic [7:0] exp_addr;

  zxuno_register_initiator dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_oe_n(cpu_oe_n),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .zxuno_wdata(zxuno_wdata), .reg_din(reg_din), .reg_oe_n(reg_oe_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (zxuno_regwr) begin
      pulses      <= pulses + 1;
      pulse_wdata <= zxuno_wdata;
      pulse_addr  <= zxuno_addr;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_start(input logic [15:0] adr, input bit wr, input logic [7:0] d, input bit m1);
    @(posedge clk); #2;
    a = adr; cpu_din = d; m1_n = m1; iorq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
  endtask

  task automatic bus_end();
    @(posedge clk); #2;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [15:0] adr, input logic [7:0] d);
    bus_start(adr, 1'b1, d, 1'b1);
    repeat (6) @(posedge clk);
    bus_end();
  endtask

  initial begin
    rst_n = 1'b0; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    cpu_din = 8'h00; reg_din = 8'h00; reg_oe_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr",  zxuno_addr,  8'h00);
    check("rst_wdata", zxuno_wdata, 8'h00);
    check("rst_regrd", zxuno_regrd, 1'b0);
    check("rst_regwr", zxuno_regwr, 1'b0);
    check("rst_oe_n",  cpu_oe_n,    1'b1);
    check("rst_dout",  cpu_dout,    8'h00);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (4) @(posedge clk); #2;

    // address then data write
    p0 = pulses;
    do_write(16'hFC3B, 8'h0E);
    exp_addr = 8'h0E;
    check("addr_wr_addr",   zxuno_addr, exp_addr);
    check("addr_wr_nopulse", pulses - p0, 0);
    p0 = pulses;
    do_write(16'hFD3B, 8'h5A);
    check("data_wr_pulses", pulses - p0, 1);
    check("data_wr_wdata",  pulse_wdata, 8'h5A);
    check("data_wr_paddr",  pulse_addr, 8'h0E);
    exp_addr = exp_addr + AINC;
    check("data_wr_addr",   zxuno_addr, exp_addr);

    // data read with a slave driving
    p0 = pulses; reg_din = 8'hA5; reg_oe_n = 1'b0;
    bus_start(16'hFD3B, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("rd_oe_n_early", cpu_oe_n, 1'b0);
    check("rd_dout_early", cpu_dout, 8'hA5);
    repeat (4) @(negedge clk);
    check("rd_regrd_mid",  zxuno_regrd, 1'b1);
    repeat (2) @(negedge clk);
    check("rd_regrd_late", zxuno_regrd, 1'b1);
    check("rd_dout_late",  cpu_dout, 8'hA5);
    bus_end();
    exp_addr = exp_addr + AINC;
    check("rd_regrd_off",  zxuno_regrd, 1'b0);
    check("rd_nopulse",    pulses - p0, 0);
    check("rd_addr",       zxuno_addr, exp_addr);

    // data read with no slave: bus not driven
    reg_oe_n = 1'b1;
    bus_start(16'hFD3B, 1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("rd_noslave_oe_n", cpu_oe_n, 1'b1);
    check("rd_noslave_dout", cpu_dout, 8'h00);
    bus_end();
    exp_addr = exp_addr + AINC;

    // address port read returns current address
    bus_start(16'hFC3B, 1'b0, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("rdaddr_oe_n",  cpu_oe_n, 1'b0);
    check("rdaddr_dout",  cpu_dout, {8'h00, exp_addr});
    check("rdaddr_regrd", zxuno_regrd, 1'b0);
    bus_end();
    check("rdaddr_addr",  zxuno_addr, exp_addr);

    // partial address match is ignored
    p0 = pulses;
    bus_start(16'h003B, 1'b1, 8'h77, 1'b1);
    repeat (3) @(negedge clk);
    check("partial_oe_n", cpu_oe_n, 1'b1);
    repeat (3) @(posedge clk);
    bus_end();
    check("partial_addr",  zxuno_addr, exp_addr);
    check("partial_pulse", pulses - p0, 0);

    // rd_n and wr_n both low
    p0 = pulses;
    @(posedge clk); #2;
    a = 16'hFD3B; cpu_din = 8'h99; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    check("both_oe_n",  cpu_oe_n, 1'b1);
    check("both_regrd", zxuno_regrd, 1'b0);
    bus_end();
    check("both_pulse", pulses - p0, 0);
    check("both_wdata", zxuno_wdata, 8'h5A);

    // M1 cycle to data port
    p0 = pulses;
    bus_start(16'hFD3B, 1'b1, 8'h66, 1'b0);
    repeat (6) @(posedge clk);
    bus_end();
    check("m1_pulse", pulses - p0, 0);
    check("m1_addr",  zxuno_addr, exp_addr);

    // wrap at FF
    do_write(16'hFC3B, 8'hFF);
    exp_addr = 8'hFF;
    check("wrap_addr_set", zxuno_addr, exp_addr);
    p0 = pulses;
    do_write(16'hFD3B, 8'h11);
    check("wrap_pulses", pulses - p0, 1);
    check("wrap_paddr",  pulse_addr, 8'hFF);
    check("wrap_wdata",  pulse_wdata, 8'h11);
    exp_addr = exp_addr + AINC;
    check("wrap_addr",   zxuno_addr, exp_addr);

    // reset in the middle of a data write, released with wr_n still low
    p0 = pulses;
    bus_start(16'hFD3B, 1'b1, 8'h33, 1'b1);
    @(posedge clk); #2; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_addr_now", zxuno_addr, 8'h00);
    repeat (2) @(posedge clk); #2; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    bus_end();
    check("midrst_pulse", pulses - p0, 0);
    check("midrst_addr",  zxuno_addr, 8'h00);
    check("midrst_wdata", zxuno_wdata, 8'h00);

    // next access after recovery works normally
    p0 = pulses;
    do_write(16'hFD3B, 8'h44);
    check("recover_pulses", pulses - p0, 1);
    check("recover_wdata",  pulse_wdata, 8'h44);
    check("recover_paddr",  pulse_addr, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/zxuno_register_initiator.md
ZXUNO_REGISTER_INITIATOR -- requirements
Module: zxuno_register_initiator

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port a, input, 16 bits: Z80 address bus.
REQ-004 SHALL have ports iorq_n, rd_n, wr_n and m1_n, inputs, 1 bit each: Z80 bus strobes, active-low.
REQ-005 SHALL have port cpu_din, input, 8 bits: Z80 data bus, write direction.
REQ-006 SHALL have port cpu_dout, output, 8 bits: data to Z80 on port reads.
REQ-007 SHALL have port cpu_oe_n, output, 1 bit: low while this block drives cpu_dout.
REQ-008 SHALL have port zxuno_addr, output, 8 bits: current register-bank address, registered.
REQ-009 SHALL have ports zxuno_regrd and zxuno_regwr, outputs, 1 bit each: register read level and register write pulse to the register slaves.
REQ-010 SHALL have port zxuno_wdata, output, 8 bits: registered write data that accompanies zxuno_regwr.
REQ-011 SHALL have port reg_din, input, 8 bits: read data muxed from the slaves.
REQ-012 SHALL have port reg_oe_n, input, 1 bit: low when some slave drives reg_din.
REQ-013 SHALL have parameters ADDRPORT (default 16'hFC3B, register-address port) and DATAPORT (default 16'hFD3B, register-data port).

Function
REQ-014 SHALL decode an I/O access only when iorq_n=0, m1_n=1 and a matches ADDRPORT or DATAPORT exactly (full 16-bit decode).
REQ-015 SHALL pass the strobe condition (decoded access AND rd_n XOR wr_n) through a 2-flop synchronizer; an access with rd_n=0 and wr_n=0 together SHALL be ignored.
REQ-016 SHALL implement a state machine with states IDLE, ADDR_WR, DATA_WR, DATA_RD and WAIT_RELEASE.
REQ-017 IDLE SHALL move on a synchronized write to ADDRPORT to ADDR_WR, on a write to DATAPORT to DATA_WR, and on a read of DATAPORT to DATA_RD; a read of ADDRPORT SHALL stay in IDLE.
REQ-018 On entry to ADDR_WR, zxuno_addr SHALL load cpu_din sampled at that clock; the state SHALL last one cycle, then go to WAIT_RELEASE; zxuno_regwr SHALL stay 0.
REQ-019 On entry to DATA_WR, zxuno_wdata SHALL load cpu_din; zxuno_regwr SHALL be 1 for exactly one clock (the DATA_WR cycle), then the state SHALL go to WAIT_RELEASE.
REQ-020 DATA_RD SHALL hold zxuno_regrd=1 for as long as the synchronized read strobe is active, then go to IDLE.
REQ-021 WAIT_RELEASE SHALL go to IDLE only after the synchronized strobe is seen inactive, so each bus access yields at most one zxuno_regwr pulse.
REQ-022 cpu_oe_n SHALL be combinational from the raw bus: 0 for an unsynchronized decoded read of ADDRPORT (cpu_dout=zxuno_addr) or of DATAPORT (cpu_dout=reg_din, only when reg_oe_n=0); otherwise 1 and cpu_dout=8'h00.
REQ-023 zxuno_addr SHALL change only in ADDR_WR, or as given in REQ-027.

Reset
REQ-024 While rst_n=0 (asynchronous): zxuno_addr=8'h00, zxuno_wdata=8'h00, zxuno_regrd=0, zxuno_regwr=0, synchronizer flops inactive, state=WAIT_RELEASE.
REQ-025 Reset asserted mid-access SHALL abort the access with no write pulse; after release, no new access SHALL start until the strobe has been seen inactive.

Configuration
REQ-026 Macro ZXUNO_ADDR_AUTOINC_EN SHALL select the address auto-increment feature.
REQ-027 When it is defined: on the WAIT_RELEASE->IDLE exit after DATA_WR, and on the DATA_RD->IDLE exit, zxuno_addr SHALL increment by 1, modulo 256 (8'hFF wraps to 8'h00).
REQ-028 When it is undefined: zxuno_addr SHALL never change except in ADDR_WR.

Verification
REQ-029 OUT (FC3B),0Eh then OUT (FD3B),5Ah -> zxuno_addr=0E, exactly one zxuno_regwr pulse with zxuno_wdata=5A.
REQ-030 IN (FD3B) with reg_oe_n=0, reg_din=A5 -> cpu_oe_n=0, cpu_dout=A5, zxuno_regrd high throughout, no regwr.
REQ-031 IN (FC3B) after zxuno_addr=0E -> cpu_dout=0E; OUT to 16'h003B (partial match) -> no change, cpu_oe_n=1.
REQ-032 Assert rst_n=0 during OUT (FD3B),33h and release while wr_n is still low -> no regwr pulse; zxuno_addr=00 after reset.
REQ-033 With ZXUNO_ADDR_AUTOINC_EN defined, zxuno_addr=FF then OUT (FD3B),11h -> pulse at address FF, then zxuno_addr=00; with it undefined, zxuno_addr stays FF.
REQ-034 An access with rd_n and wr_n both low, and an access with m1_n=0 to FD3B -> no strobes and no state change.
